avmm_rr_arbiter: RTL and testbench
==================================

# avmm_rr_arbiter

Round-robin arbiter that shares one Avalon-MM master port, typically the path to the on-board memory slave, between NUM_REQ Avalon-MM requester ports. Each accepted command is forwarded whole to the shared master. Read responses come back in order with variable latency, and each one is routed to the requester that issued it through an in-order ID FIFO. The block sits between the DMA/PCIe-bridge masters and the memory interconnect, and is verified against the Avalon-MM slave BFM.

## Interface
- NUM_REQ, 2: number of requester ports (2..8).
- ADDR_W, 26: address width.
- DATA_W, 32: data width.
- MAX_PEND, 4: maximum outstanding reads (ID FIFO depth, power of 2).
- clk  in  1  sole clock; all state updates on the rising edge.
- reset_n  in  1  synchronous, active-low reset.
- avs_address  in  NUM_REQ*ADDR_W  per-requester address; requester i uses slice i.
- avs_read, avs_write  in  NUM_REQ each  per-requester command strobes.
- avs_writedata  in  NUM_REQ*DATA_W  per-requester write data.
- avs_byteenable  in  NUM_REQ*DATA_W/8  per-requester byte enables.
- avs_waitrequest  out  NUM_REQ  per-requester stall.
- avs_readdata  out  DATA_W  broadcast of avm_readdata.
- avs_readdatavalid  out  NUM_REQ  one-hot response strobe.
- avm_address, avm_writedata, avm_byteenable  out  ADDR_W / DATA_W / DATA_W/8  shared master command fields.
- avm_read, avm_write  out  1 each  shared master strobes.
- avm_waitrequest  in  1  slave stall.
- avm_readdata  in  DATA_W  slave read data.
- avm_readdatavalid  in  1  slave response strobe.
- rsp_error  out  1  sticky flag; set when avm_readdatavalid arrives while the ID FIFO is empty.

## Operation
- The FSM has two states, IDLE and GRANT, with a registered grant index gnt and a round-robin pointer rr.
- In IDLE, any request (avs_read[i] or avs_write[i]) moves the FSM to GRANT. gnt is set to the first requesting index at or after rr, wrapping modulo NUM_REQ.
- In GRANT, avm_* fields are driven combinationally from requester gnt, and no other requester's fields reach avm_*.
- A command is accepted in a cycle where avm_read or avm_write is high and avm_waitrequest is low. In that same cycle:
  - avs_waitrequest[gnt] is 0.
  - rr is updated to gnt+1, wrapping modulo NUM_REQ.
  - gnt is re-arbitrated from the current requests. Index gnt has the lowest priority. The FSM stays in GRANT if any request exists and goes to IDLE otherwise.
- In GRANT, if requester gnt drops both strobes without acceptance, the FSM returns to IDLE on the next edge. Requesters must hold their commands while stalled (Avalon rule), so this case occurs only after a grant that was re-issued after acceptance.
- Every avs_waitrequest bit except the accepting one is 1 in every cycle.
- If read and write are both high on the granted port, the read is forwarded and the write is ignored.
- Read tracking:
  - An accepted read pushes gnt into the ID FIFO.
  - avm_readdatavalid pops the FIFO head h and drives avs_readdatavalid[h]=1 in the same cycle.
  - A push and a pop in the same cycle are both performed, and the count is unchanged.
- FIFO full (count==MAX_PEND): a granted read is held. avm_read is 0 and avs_waitrequest[gnt] is 1 until count<MAX_PEND, and the grant is kept. A same-cycle pop does not release a full FIFO; release happens on the following cycle.
- Writes are never blocked by the FIFO and produce no response.
- Stray response (avm_readdatavalid with FIFO empty): no avs_readdatavalid is asserted and rsp_error is set to 1. rsp_error clears only on reset.

## Timing
- Reset values: FSM=IDLE, gnt=0, rr=0, FIFO empty, rsp_error=0. Consequently avm_read=avm_write=0, avs_waitrequest=all 1s, avs_readdatavalid=0.
- Reset mid-operation: all outstanding IDs are discarded. Responses arriving after reset are treated as stray.
- Grant latency: a request first seen in cycle N (FSM in IDLE) appears on avm_* in cycle N+1.
- Back-to-back: with continuous requests and no slave stalls, one command is accepted every cycle.
- Response routing latency is 0 cycles: avs_readdata and avs_readdatavalid are combinational from avm_readdata and avm_readdatavalid.
- Fairness: while requesting continuously, a requester waits for at most NUM_REQ-1 other commands before it is accepted.

## Test plan
- Single read, port 0: address 0x010, slave BFM latency 3, data 0xDEADBEEF -> avm_read in cycle 1; avs_readdatavalid=2'b01 with avs_readdata=0xDEADBEEF 3 cycles after acceptance.
- Both ports write continuously, each to its own address range, with avm_waitrequest=0 -> accepted ports alternate 0,1,0,1,...; the BFM memory holds every written word.
- Port 0 reads address 0x20 and port 1 reads address 0x30, issued back to back; the slave returns 0x11111111 then 0x22222222 -> valid pulses go first to port 0, then to port 1, with matching data.
- Port 0 issues 5 reads and the slave withholds responses (MAX_PEND=4) -> the 5th read stalls with avm_read=0; it is issued one cycle after the first response.
- Slave holds avm_waitrequest=1 for 2 cycles (matching the BFM wait time of 2) -> the requester's command is held stable, and avs_waitrequest stays 1 until acceptance.
- Reset asserted with 2 reads outstanding, then 2 responses arrive -> no avs_readdatavalid is asserted, rsp_error=1, and all outputs show their reset values during reset.

Source files
------------

// File: rtl/avmm_rr_arbiter.sv
// Round-robin arbiter sharing one Avalon-MM master among NUM_REQ requesters.
// Read responses are routed back in order through a small ID FIFO.
//
// state | meaning
// IDLE  | no grant held; waiting for any requester strobe
// GRANT | requester gnt drives avm_*; re-arbitrates on each acceptance
module avmm_rr_arbiter #(
   parameter int NUM_REQ  = 2,
   parameter int ADDR_W   = 26,
   parameter int DATA_W   = 32,
   parameter int MAX_PEND = 4
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic [NUM_REQ*ADDR_W-1:0]  avs_address,
   input  logic [NUM_REQ-1:0]         avs_read,
   input  logic [NUM_REQ-1:0]         avs_write,
   input  logic [NUM_REQ*DATA_W-1:0]  avs_writedata,
   input  logic [NUM_REQ*DATA_W/8-1:0] avs_byteenable,
   output logic [NUM_REQ-1:0]         avs_waitrequest,
   output logic [DATA_W-1:0]          avs_readdata,
   output logic [NUM_REQ-1:0]         avs_readdatavalid,
   output logic [ADDR_W-1:0]          avm_address,
   output logic [DATA_W-1:0]          avm_writedata,
   output logic [DATA_W/8-1:0]        avm_byteenable,
   output logic                       avm_read,
   output logic                       avm_write,
   input  logic                       avm_waitrequest,
   input  logic [DATA_W-1:0]          avm_readdata,
   input  logic                       avm_readdatavalid,
   output logic                       rsp_error
);

   localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int PW = (MAX_PEND > 1) ? $clog2(MAX_PEND) : 1;
   localparam int CW = PW + 1;
   localparam int BW = DATA_W / 8;

   typedef enum logic {IDLE, GRANT} state_t;

   state_t             state, state_nxt;
   logic [GW-1:0]      gnt, gnt_nxt, rr, rr_nxt, gnt_inc;
   logic [GW-1:0]      id_mem [MAX_PEND];
   logic [PW-1:0]      wr_ptr, rd_ptr;
   logic [CW-1:0]      count;
   logic [GW-1:0]      head;
   logic [NUM_REQ-1:0] req;
   logic               g_read, g_write;
   logic               fifo_full, fifo_empty;
   logic               accept, push, pop;

   // First requesting index at or after start, wrapping.
   function automatic logic [GW-1:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                             input logic [GW-1:0] start);
      logic [GW-1:0] sel;
      logic          found;
      int            idx;
      sel   = start;
      found = 1'b0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = (int'(start) + k) % NUM_REQ;
         if (!found && r[idx]) begin
            sel   = GW'(idx);
            found = 1'b1;
         end
      end
      return sel;
   endfunction

   assign req        = avs_read | avs_write;
   assign gnt_inc    = (gnt == GW'(NUM_REQ - 1)) ? '0 : gnt + 1'b1;
   assign fifo_full  = (count == CW'(MAX_PEND));
   assign fifo_empty = (count == '0);
   assign g_read     = (state == GRANT) && avs_read[gnt];
   assign g_write    = (state == GRANT) && avs_write[gnt];

   // A held read blocks the write strobe too: read wins when both are set.
   assign avm_read   = g_read && !fifo_full;
   assign avm_write  = g_write && !g_read;
   assign accept     = (avm_read || avm_write) && !avm_waitrequest;

   assign push       = accept && avm_read;
   assign pop        = avm_readdatavalid && !fifo_empty;
   assign head       = id_mem[rd_ptr];

   assign avs_readdata = avm_readdata;

   always_comb begin
      avm_address     = '0;
      avm_writedata   = '0;
      avm_byteenable  = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (gnt == GW'(i)) begin
            avm_address    = avs_address[i*ADDR_W +: ADDR_W];
            avm_writedata  = avs_writedata[i*DATA_W +: DATA_W];
            avm_byteenable = avs_byteenable[i*BW +: BW];
         end
      end
   end

   always_comb begin
      avs_waitrequest = '1;
      if (accept)
         avs_waitrequest[gnt] = 1'b0;
      avs_readdatavalid = '0;
      for (int i = 0; i < NUM_REQ; i++)
         avs_readdatavalid[i] = pop && (head == GW'(i));
   end

   always_comb begin
      state_nxt = state;
      gnt_nxt   = gnt;
      rr_nxt    = rr;
      case (state)
         IDLE: begin
            if (|req) begin
               state_nxt = GRANT;
               gnt_nxt   = rr_pick(req, rr);
            end
         end
         GRANT: begin
            if (accept) begin
               rr_nxt = gnt_inc;
               if (|req)
                  gnt_nxt = rr_pick(req, gnt_inc);
               else
                  state_nxt = IDLE;
            end else if (!req[gnt]) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state     <= IDLE;
         gnt       <= '0;
         rr        <= '0;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         rsp_error <= 1'b0;
      end else begin
         state <= state_nxt;
         gnt   <= gnt_nxt;
         rr    <= rr_nxt;
         if (push)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         if (avm_readdatavalid && fifo_empty)
            rsp_error <= 1'b1;
      end
   end

   // ID storage needs no reset; validity is tracked by count and the pointers.
   always_ff @(posedge clk) begin
      if (push)
         id_mem[wr_ptr] <= gnt;
   end

endmodule

// File: tb/tb_avmm_rr_arbiter.sv
// Directed bench for avmm_rr_arbiter (2 requesters, MAX_PEND=4).
// The slave side is driven by hand with the expected cycle-level behaviour.
module tb_avmm_rr_arbiter;

   localparam int NR = 2;
   localparam int AW = 26;
   localparam int DW = 32;

   logic              clk = 1'b0;
   logic              reset_n;
   logic [NR*AW-1:0]  avs_address;
   logic [NR-1:0]     avs_read, avs_write;
   logic [NR*DW-1:0]  avs_writedata;
   logic [NR*DW/8-1:0] avs_byteenable;
   logic [NR-1:0]     avs_waitrequest;
   logic [DW-1:0]     avs_readdata;
   logic [NR-1:0]     avs_readdatavalid;
   logic [AW-1:0]     avm_address;
   logic [DW-1:0]     avm_writedata;
   logic [DW/8-1:0]   avm_byteenable;
   logic              avm_read, avm_write;
   logic              avm_waitrequest;
   logic [DW-1:0]     avm_readdata;
   logic              avm_readdatavalid;
   logic              rsp_error;

   int total = 0;
   int bad   = 0;

   avmm_rr_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .MAX_PEND(4)) dut (
      .clk               (clk),
      .reset_n           (reset_n),
      .avs_address       (avs_address),
      .avs_read          (avs_read),
      .avs_write         (avs_write),
      .avs_writedata     (avs_writedata),
      .avs_byteenable    (avs_byteenable),
      .avs_waitrequest   (avs_waitrequest),
      .avs_readdata      (avs_readdata),
      .avs_readdatavalid (avs_readdatavalid),
      .avm_address       (avm_address),
      .avm_writedata     (avm_writedata),
      .avm_byteenable    (avm_byteenable),
      .avm_read          (avm_read),
      .avm_write         (avm_write),
      .avm_waitrequest   (avm_waitrequest),
      .avm_readdata      (avm_readdata),
      .avm_readdatavalid (avm_readdatavalid),
      .rsp_error         (rsp_error)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic set_port(input int p, input logic [AW-1:0] a, input logic [DW-1:0] d);
      avs_address[p*AW +: AW]      = a;
      avs_writedata[p*DW +: DW]    = d;
      avs_byteenable[p*DW/8 +: DW/8] = '1;
   endtask

   task automatic do_reset;
      reset_n           = 1'b0;
      avs_read          = '0;
      avs_write         = '0;
      avm_waitrequest   = 1'b0;
      avm_readdatavalid = 1'b0;
      tick;
      tick;
      reset_n = 1'b1;
   endtask

   int          cnt [NR];
   int          exp_p, last_p;
   logic [AW-1:0] base [NR];

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      avs_address    = '0;
      avs_writedata  = '0;
      avs_byteenable = '0;
      avm_readdata   = '0;

      // reset values
      do_reset;
      reset_n = 1'b0;
      #1;
      chk("rst_avm_read",  avm_read, 0);
      chk("rst_avm_write", avm_write, 0);
      chk("rst_waitreq",   avs_waitrequest, 2'b11);
      chk("rst_rdvalid",   avs_readdatavalid, 2'b00);
      chk("rst_rsp_error", rsp_error, 0);
      reset_n = 1'b1;

      // single read from port 0, slave latency 3
      set_port(0, 26'h010, 32'h0);
      avs_read = 2'b01;
      #1;
      chk("rd0_idle_read", avm_read, 0);
      chk("rd0_idle_wait", avs_waitrequest, 2'b11);
      tick;
      chk("rd0_avm_read", avm_read, 1);
      chk("rd0_addr",     avm_address, 26'h010);
      chk("rd0_wait",     avs_waitrequest, 2'b10);
      chk("rd0_be",       avm_byteenable, 4'hF);
      tick;
      avs_read = 2'b00;
      #1;
      chk("rd0_dropped",  avm_read, 0);
      chk("rd0_no_rsp",   avs_readdatavalid, 2'b00);
      tick;
      tick;
      avm_readdatavalid = 1'b1;
      avm_readdata      = 32'hDEADBEEF;
      #1;
      chk("rd0_rsp_valid", avs_readdatavalid, 2'b01);
      chk("rd0_rsp_data",  avs_readdata, 32'hDEADBEEF);
      tick;
      avm_readdatavalid = 1'b0;
      #1;
      chk("rd0_rsp_end", avs_readdatavalid, 2'b00);

      // continuous writes from both ports alternate 0,1,0,1
      do_reset;
      base[0] = 26'h100;
      base[1] = 26'h200;
      for (int p = 0; p < NR; p++) begin
         cnt[p] = 0;
         set_port(p, base[p] + AW'(cnt[p]), 32'hA000_0000 + 32'(p * 'h100 + cnt[p]));
      end
      avs_write = 2'b11;
      #1;
      chk("wr_idle_wait", avs_waitrequest, 2'b11);
      exp_p  = 0;
      last_p = 0;
      for (int k = 0; k < 8; k++) begin
         tick;
         if (k > 0) begin
            cnt[last_p]++;
            set_port(last_p, base[last_p] + AW'(cnt[last_p]),
                     32'hA000_0000 + 32'(last_p * 'h100 + cnt[last_p]));
         end
         #1;
         chk("wr_strobe", avm_write, 1);
         chk("wr_wait",   avs_waitrequest, (exp_p == 0) ? 2'b10 : 2'b01);
         chk("wr_addr",   avm_address, base[exp_p] + AW'(cnt[exp_p]));
         chk("wr_data",   avm_writedata, 32'hA000_0000 + 32'(exp_p * 'h100 + cnt[exp_p]));
         last_p = exp_p;
         exp_p  = 1 - exp_p;
      end
      tick;
      avs_write = 2'b00;
      #1;
      chk("wr_done", avm_write, 0);

      // back-to-back reads from ports 0 and 1, in-order responses
      tick;
      set_port(0, 26'h20, 32'h0);
      set_port(1, 26'h30, 32'h0);
      avs_read = 2'b11;
      #1;
      tick;
      chk("rr_rd0_read", avm_read, 1);
      chk("rr_rd0_addr", avm_address, 26'h20);
      chk("rr_rd0_wait", avs_waitrequest, 2'b10);
      tick;
      avs_read = 2'b10;
      #1;
      chk("rr_rd1_addr", avm_address, 26'h30);
      chk("rr_rd1_wait", avs_waitrequest, 2'b01);
      tick;
      avs_read = 2'b00;
      #1;
      chk("rr_idle", avm_read, 0);
      tick;
      avm_readdatavalid = 1'b1;
      avm_readdata      = 32'h11111111;
      #1;
      chk("rr_rsp0_valid", avs_readdatavalid, 2'b01);
      chk("rr_rsp0_data",  avs_readdata, 32'h11111111);
      tick;
      avm_readdata = 32'h22222222;
      #1;
      chk("rr_rsp1_valid", avs_readdatavalid, 2'b10);
      chk("rr_rsp1_data",  avs_readdata, 32'h22222222);
      tick;
      avm_readdatavalid = 1'b0;
      #1;
      chk("rr_rsp_end", avs_readdatavalid, 2'b00);

      // five reads with responses withheld: the fifth waits for a free slot
      set_port(0, 26'h40, 32'h0);
      avs_read = 2'b01;
      #1;
      chk("full_idle", avm_read, 0);
      for (int k = 0; k < 4; k++) begin
         tick;
         if (k > 0)
            set_port(0, 26'h40 + AW'(k), 32'h0);
         #1;
         chk("full_fill_read", avm_read, 1);
         chk("full_fill_wait", avs_waitrequest, 2'b10);
         chk("full_fill_addr", avm_address, 26'h40 + AW'(k));
      end
      tick;
      set_port(0, 26'h44, 32'h0);
      #1;
      chk("full_hold_read", avm_read, 0);
      chk("full_hold_wait", avs_waitrequest, 2'b11);
      tick;
      chk("full_hold2_read", avm_read, 0);
      tick;
      avm_readdatavalid = 1'b1;
      avm_readdata      = 32'h0000_0005;
      #1;
      chk("full_pop_valid", avs_readdatavalid, 2'b01);
      chk("full_pop_read",  avm_read, 0);
      chk("full_pop_wait",  avs_waitrequest, 2'b11);
      tick;
      avm_readdatavalid = 1'b0;
      #1;
      chk("full_rel_read", avm_read, 1);
      chk("full_rel_wait", avs_waitrequest, 2'b10);
      chk("full_rel_addr", avm_address, 26'h44);
      tick;
      avs_read = 2'b00;
      for (int k = 0; k < 4; k++) begin
         avm_readdatavalid = 1'b1;
         #1;
         chk("full_drain", avs_readdatavalid, 2'b01);
         tick;
      end
      avm_readdatavalid = 1'b0;
      #1;
      chk("drain_no_err", rsp_error, 0);

      // slave stall of two cycles on a port-1 write
      avm_waitrequest = 1'b1;
      set_port(1, 26'h55, 32'hCAFE0055);
      avs_write = 2'b10;
      #1;
      chk("stall_idle_wait", avs_waitrequest, 2'b11);
      for (int k = 0; k < 2; k++) begin
         tick;
         chk("stall_write", avm_write, 1);
         chk("stall_addr",  avm_address, 26'h55);
         chk("stall_data",  avm_writedata, 32'hCAFE0055);
         chk("stall_wait",  avs_waitrequest, 2'b11);
      end
      tick;
      avm_waitrequest = 1'b0;
      #1;
      chk("stall_accept_wait", avs_waitrequest, 2'b01);
      chk("stall_accept_wr",   avm_write, 1);
      tick;
      avs_write = 2'b00;
      #1;
      chk("stall_done", avm_write, 0);

      // reset with two reads outstanding; later responses are stray
      tick;
      set_port(0, 26'h60, 32'h0);
      avs_read = 2'b01;
      #1;
      tick;
      chk("rst_rd_a", avs_waitrequest, 2'b10);
      tick;
      set_port(0, 26'h61, 32'h0);
      #1;
      chk("rst_rd_b", avs_waitrequest, 2'b10);
      tick;
      avs_read = 2'b11;
      reset_n  = 1'b0;
      #1;
      tick;
      chk("mid_rst_read",   avm_read, 0);
      chk("mid_rst_write",  avm_write, 0);
      chk("mid_rst_wait",   avs_waitrequest, 2'b11);
      chk("mid_rst_rdv",    avs_readdatavalid, 2'b00);
      chk("mid_rst_err",    rsp_error, 0);
      avs_read = 2'b00;
      tick;
      reset_n           = 1'b1;
      avm_readdatavalid = 1'b1;
      avm_readdata      = 32'h33333333;
      #1;
      chk("stray1_rdv", avs_readdatavalid, 2'b00);
      tick;
      chk("stray2_rdv", avs_readdatavalid, 2'b00);
      chk("stray1_err", rsp_error, 1);
      tick;
      avm_readdatavalid = 1'b0;
      #1;
      chk("stray_err_sticky", rsp_error, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
